// File: rtl/tc_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module : tc_mult_pkg
// Shared product width, saturation bounds and counter width for tc_pipe_mult.
// Rev    : 1.0
// ============================================================================
package tc_mult_pkg;

    localparam int SAT_CNT_W = 16;
    localparam int BOUND_W   = 128;

    // Both operands gain one extension bit, so the exact product needs two extra bits.
    function automatic int prod_w(input int a_w, input int b_w);
        return a_w + b_w + 2;
    endfunction

    function automatic logic [BOUND_W-1:0] sat_hi(input int out_w);
        return (BOUND_W'(1) << (out_w - 1)) - BOUND_W'(1);
    endfunction

    function automatic logic [BOUND_W-1:0] sat_lo(input int out_w);
        return BOUND_W'(1) << (out_w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tc_mult_sat.sv
`default_nettype none
// ============================================================================
// Module : tc_mult_sat
// Combinational round, arithmetic shift and saturate/wrap of a full product.
// Rev    : 1.0
// ============================================================================
module tc_mult_sat
    import tc_mult_pkg::*;
#(
    parameter int PROD_W = 36,
    parameter int OUT_W  = 33,
    parameter int SHIFT  = 0,
    parameter int ROUND  = 0,
    parameter int SAT    = 1
) (
    input  logic signed [PROD_W-1:0] i_prod,
    output logic signed [OUT_W-1:0]  o_dout,
    output logic                     o_ovf
);

    localparam int c_RW  = PROD_W + 1;
    localparam int c_RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [c_RW-1:0] c_RND = (ROUND != 0 && SHIFT > 0) ? (c_RW'(1) << c_RSH) : '0;
    localparam logic [BOUND_W-1:0] c_HI_FULL = sat_hi(OUT_W);
    localparam logic [BOUND_W-1:0] c_LO_FULL = sat_lo(OUT_W);
    localparam logic [OUT_W-1:0]   c_HI = c_HI_FULL[OUT_W-1:0];
    localparam logic [OUT_W-1:0]   c_LO = c_LO_FULL[OUT_W-1:0];

    logic signed [c_RW-1:0] w_r;
    logic signed [c_RW-1:0] w_s;

    assign w_r = {i_prod[PROD_W-1], i_prod} + c_RND;
    assign w_s = w_r >>> SHIFT;

    generate
        if (OUT_W >= c_RW) begin : g_fit
            assign o_dout = OUT_W'(w_s);
            assign o_ovf  = 1'b0;
        end else begin : g_clip
            logic [c_RW-OUT_W:0] w_top;
            logic                w_ovf;

            // In range exactly when every bit above the output sign bit repeats it.
            assign w_top  = w_s[c_RW-1:OUT_W-1];
            assign w_ovf  = !((&w_top) || !(|w_top));
            assign o_ovf  = w_ovf;
            assign o_dout = (w_ovf && SAT != 0) ? (w_s[c_RW-1] ? c_LO : c_HI)
                                                : w_s[OUT_W-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/tc_pipe_mult.sv
`default_nettype none
// ============================================================================
// Module : tc_pipe_mult
// Pipelined fixed-point multiplier with valid/ready flow, rounding and saturation.
// Rev    : 1.0
// ============================================================================
module tc_pipe_mult
    import tc_mult_pkg::*;
#(
    parameter int A_W      = 16,
    parameter int B_W      = 18,
    parameter int A_SIGNED = 0,
    parameter int B_SIGNED = 1,
    parameter int OUT_W    = 33,
    parameter int SHIFT    = 0,
    parameter int ROUND    = 0,
    parameter int SAT      = 1,
    parameter int STAGES   = 1
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [A_W-1:0]           din0,
    input  logic [B_W-1:0]           din1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  dout,
    output logic                     ovf,
    output logic [SAT_CNT_W-1:0]     sat_count
);

    localparam int c_PW = prod_w(A_W, B_W);

    logic                    w_adv;
    logic signed [A_W:0]     w_a;
    logic signed [B_W:0]     w_b;
    logic signed [c_PW-1:0]  w_a_x;
    logic signed [c_PW-1:0]  w_b_x;
    logic signed [c_PW-1:0]  w_prod;
    logic signed [c_PW-1:0]  w_sat_in;
    logic signed [OUT_W-1:0] w_dout;
    logic                    w_ovf;

    logic [STAGES-1:0]       r_vld;
    logic signed [OUT_W-1:0] r_dout;
    logic                    r_ovf;
    logic [SAT_CNT_W-1:0]    r_sat_cnt;

    // Whole pipeline moves in lockstep; bubbles are never squeezed out.
    assign w_adv    = out_ready || !r_vld[STAGES-1];
    assign in_ready = w_adv;

    assign w_a    = (A_SIGNED != 0) ? {din0[A_W-1], din0} : {1'b0, din0};
    assign w_b    = (B_SIGNED != 0) ? {din1[B_W-1], din1} : {1'b0, din1};
    assign w_a_x  = c_PW'(w_a);
    assign w_b_x  = c_PW'(w_b);
    assign w_prod = w_a_x * w_b_x;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld <= (r_vld << 1) | STAGES'(in_valid);
        end
    end

    generate
        if (STAGES == 1) begin : g_direct
            assign w_sat_in = w_prod;
        end else begin : g_piped
            // Product registers ahead of the output stage, left for retiming into the DSP.
            logic signed [c_PW-1:0] r_prod [STAGES-1];

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int i = 0; i < STAGES - 1; i++) begin
                        r_prod[i] <= '0;
                    end
                end else if (w_adv) begin
                    r_prod[0] <= w_prod;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        r_prod[i] <= r_prod[i-1];
                    end
                end
            end

            assign w_sat_in = r_prod[STAGES-2];
        end
    endgenerate

    tc_mult_sat #(
        .PROD_W (c_PW),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT),
        .ROUND  (ROUND),
        .SAT    (SAT)
    ) u_sat (
        .i_prod (w_sat_in),
        .o_dout (w_dout),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_dout <= '0;
            r_ovf  <= 1'b0;
        end else if (w_adv) begin
            r_dout <= w_dout;
            r_ovf  <= w_ovf;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_sat_cnt <= '0;
        end else if (r_vld[STAGES-1] && out_ready && r_ovf && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + SAT_CNT_W'(1);
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign dout      = r_dout;
    assign ovf       = r_ovf;
    assign sat_count = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tc_pipe_mult.sv
`default_nettype none
// ============================================================================
// Module : tb_tc_pipe_mult
// Three configurations of tc_pipe_mult driven in parallel against a reference model.
// Rev    : 1.0
// ============================================================================
module tb_tc_pipe_mult;

    typedef struct {
        longint d;
        bit     o;
    } exp_t;

    typedef struct {
        int     a;
        int     b;
        longint d_sat;
        bit     o_sat;
        longint d_wrap;
        bit     o_wrap;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] din0;
    logic [17:0] din1;

    logic               def_ir, def_ov, def_o;
    logic signed [32:0] def_d;
    logic [15:0]        def_sc;
    logic               wrap_ir, wrap_ov, wrap_o;
    logic signed [32:0] wrap_d;
    logic [15:0]        wrap_sc;
    logic               rnd_ir, rnd_ov, rnd_o;
    logic signed [32:0] rnd_d;
    logic [15:0]        rnd_sc;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q_def[$];
    exp_t q_wrap[$];
    exp_t q_rnd[$];
    int   acc_rnd = 0;
    int   out_rnd = 0;

    always #5 clk = ~clk;

    tc_pipe_mult u_def (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(def_ir),
        .din0(din0), .din1(din1), .out_valid(def_ov), .out_ready(out_ready),
        .dout(def_d), .ovf(def_o), .sat_count(def_sc)
    );

    tc_pipe_mult #(.SAT(0)) u_wrap (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(wrap_ir),
        .din0(din0), .din1(din1), .out_valid(wrap_ov), .out_ready(out_ready),
        .dout(wrap_d), .ovf(wrap_o), .sat_count(wrap_sc)
    );

    tc_pipe_mult #(.SHIFT(4), .ROUND(1), .STAGES(3)) u_rnd (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rnd_ir),
        .din0(din0), .din1(din1), .out_valid(rnd_ov), .out_ready(out_ready),
        .dout(rnd_d), .ovf(rnd_o), .sat_count(rnd_sc)
    );

    // Reference: exact 64-bit product, round, floor shift, then clamp or wrap to 33 bits.
    function automatic exp_t model(input logic [15:0] a, input logic [17:0] b,
                                   input int sh, input bit rnd, input bit sat);
        exp_t   e;
        longint p, r, s, lo, hi;
        lo = -(64'sd1 <<< 32);
        hi = (64'sd1 <<< 32) - 64'sd1;
        p  = longint'(a) * longint'($signed(b));
        r  = p + ((rnd && sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0);
        s  = r >>> sh;
        if (s >= lo && s <= hi) begin
            e.d = s;
            e.o = 1'b0;
        end else begin
            e.o = 1'b1;
            e.d = sat ? ((s < 0) ? lo : hi) : ((s <<< 31) >>> 31);
        end
        return e;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic sb_cmp(input string nm, input exp_t e, input longint d, input bit o);
        n_cmp++;
        if (e.d !== d || e.o !== o) begin
            n_bad++;
            $display("FAIL %s: got dout=%0d ovf=%0d expected dout=%0d ovf=%0d", nm, d, o, e.d, e.o);
        end
    endtask

    task automatic sb_extra(input string nm, input longint d);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected output dout=%0d expected none", nm, d);
    endtask

    // Handshakes are evaluated mid-cycle; they take effect at the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_def.delete();
            q_wrap.delete();
            q_rnd.delete();
            acc_rnd = 0;
            out_rnd = 0;
        end else begin
            if (def_ov && out_ready) begin
                if (q_def.size() == 0) sb_extra("sb_def", def_d);
                else sb_cmp("sb_def", q_def.pop_front(), def_d, def_o);
            end
            if (wrap_ov && out_ready) begin
                if (q_wrap.size() == 0) sb_extra("sb_wrap", wrap_d);
                else sb_cmp("sb_wrap", q_wrap.pop_front(), wrap_d, wrap_o);
            end
            if (rnd_ov && out_ready) begin
                out_rnd++;
                if (q_rnd.size() == 0) sb_extra("sb_rnd", rnd_d);
                else sb_cmp("sb_rnd", q_rnd.pop_front(), rnd_d, rnd_o);
            end
            if (in_valid && def_ir)  q_def.push_back(model(din0, din1, 0, 1'b0, 1'b1));
            if (in_valid && wrap_ir) q_wrap.push_back(model(din0, din1, 0, 1'b0, 1'b0));
            if (in_valid && rnd_ir) begin
                acc_rnd++;
                q_rnd.push_back(model(din0, din1, 4, 1'b1, 1'b1));
            end
        end
    end

    task automatic rnd_single(input int a, input int b, input longint exp_d, input string nm);
        din0     = 16'(a);
        din1     = 18'(b);
        in_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            check({nm, "_valid_c", $sformatf("%0d", c)}, rnd_ov, (c == 3) ? 1 : 0);
        end
        check({nm, "_dout"}, rnd_d, exp_d);
    endtask

    vec_t   tbl[9];
    int     n_ovf;
    int     sent;
    int     cyc;
    longint held;

    initial begin
        tbl[0] = '{1000,   -3,      -64'sd3000,       1'b0, -64'sd3000,       1'b0};
        tbl[1] = '{65535,  -131072, -64'sd4294967296, 1'b1, 64'sd131072,      1'b1};
        tbl[2] = '{65535,  131071,  64'sd4294967295,  1'b1, -64'sd196607,     1'b1};
        tbl[3] = '{0,      -131072, 64'sd0,           1'b0, 64'sd0,           1'b0};
        tbl[4] = '{1,      -1,      -64'sd1,          1'b0, -64'sd1,          1'b0};
        tbl[5] = '{65535,  1,       64'sd65535,       1'b0, 64'sd65535,       1'b0};
        tbl[6] = '{32768,  -131072, -64'sd4294967296, 1'b0, -64'sd4294967296, 1'b0};
        tbl[7] = '{65535,  65537,   64'sd4294967295,  1'b0, 64'sd4294967295,  1'b0};
        tbl[8] = '{65535,  65538,   64'sd4294967295,  1'b1, -64'sd4294901762, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din0      = '0;
        din1      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_def_valid", def_ov, 0);
        check("rst_def_ready", def_ir, 1);
        check("rst_def_dout",  def_d, 0);
        check("rst_def_ovf",   def_o, 0);
        check("rst_def_cnt",   def_sc, 0);
        check("rst_rnd_valid", rnd_ov, 0);
        check("rst_rnd_ready", rnd_ir, 1);
        check("rst_wrap_cnt",  wrap_sc, 0);

        // Table: one-cycle latency and exact saturation / wrap values at the range edges.
        n_ovf = 0;
        for (int i = 0; i < 9; i++) begin
            din0     = 16'(tbl[i].a);
            din1     = 18'(tbl[i].b);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("tbl%0d_def_valid", i), def_ov, 1);
            check($sformatf("tbl%0d_def_dout", i), def_d, tbl[i].d_sat);
            check($sformatf("tbl%0d_def_ovf", i), def_o, tbl[i].o_sat);
            check($sformatf("tbl%0d_wrap_dout", i), wrap_d, tbl[i].d_wrap);
            check($sformatf("tbl%0d_wrap_ovf", i), wrap_o, tbl[i].o_wrap);
            if (tbl[i].o_sat) n_ovf++;
        end
        @(negedge clk);
        check("def_sat_count",  def_sc, n_ovf);
        check("wrap_sat_count", wrap_sc, n_ovf);
        check("rnd_sat_count",  rnd_sc, 0);
        repeat (4) @(negedge clk);

        // Round-half-up after a 4-bit shift: 700/16 = 43.75 -> 44, -700/16 -> -44.
        rnd_single(100, 7,  64'sd44,  "rnd_pos");
        rnd_single(100, -7, -64'sd44, "rnd_neg");
        repeat (4) @(negedge clk);

        // Ten back-to-back operands with a four-cycle output stall in the middle.
        @(posedge clk);
        #1;
        sent     = 0;
        cyc      = 0;
        held     = 0;
        din0     = 16'(50 + 37 * sent);
        din1     = 18'(1234 * sent - 6000);
        in_valid = 1'b1;
        while (sent < 10 && cyc < 60) begin
            out_ready = !(cyc >= 5 && cyc < 9);
            @(negedge clk);
            if (!out_ready) begin
                check("stall_in_ready",  rnd_ir, 0);
                check("stall_out_valid", rnd_ov, 1);
                if (cyc == 5) held = rnd_d;
                else check("stall_dout_stable", rnd_d, held);
            end
            if (rnd_ir) sent++;
            @(posedge clk);
            #1;
            din0 = 16'(50 + 37 * sent);
            din1 = 18'(1234 * sent - 6000);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", sent, 10);
        repeat (8) @(negedge clk);
        check("stream_rnd_count", out_rnd, acc_rnd);
        check("stream_rnd_drained", q_rnd.size(), 0);
        check("stream_def_drained", q_def.size(), 0);

        // Reset with three operands in flight in the three-stage instance.
        for (int k = 0; k < 3; k++) begin
            din0     = 16'(300 + k);
            din1     = 18'(-5 - k);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rnd_valid", rnd_ov, 0);
        check("async_rst_def_cnt",   def_sc, 0);
        check("async_rst_wrap_cnt",  wrap_sc, 0);
        check("async_rst_rnd_dout",  rnd_d, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", rnd_ir, 1);
        check("post_rst_valid", rnd_ov, 0);
        rnd_single(100, -7, -64'sd44, "post_rst");
        repeat (5) @(negedge clk);
        check("final_rnd_drained", q_rnd.size(), 0);
        check("final_rnd_count", out_rnd, acc_rnd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
